// File: rtl/seq_match_sched.sv
// Round-robin scheduler sharing one programmable serial pattern matcher among NCH requesters.
// Define SEQ_MATCH_NONOVERLAP_EN for non-overlapping detection (history clears after each hit).
module seq_match_sched #(
    parameter int NCH = 4,
    parameter int CHW = 2,
    parameter int PW  = 8,
    parameter int LW  = 4,
    parameter int CW  = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [PW-1:0]  cfg_pattern,
    input  logic [LW-1:0]  cfg_len,
    input  logic [NCH-1:0] req,
    input  logic [NCH-1:0] bit_in,
    input  logic [NCH-1:0] bit_vld,
    input  logic [NCH-1:0] bit_last,
    output logic [NCH-1:0] grant,
    output logic           busy,
    output logic           match_pulse,
    output logic           done,
    output logic [CHW-1:0] done_ch,
    output logic [CW-1:0]  match_cnt
);

    typedef enum logic [1:0] {IDLE, RUN, REPORT} state_t;

    state_t         state;
    logic [CHW-1:0] rr_ptr;
    logic [CHW-1:0] cur_ch;
    logic [PW-2:0]  hist;
    logic [PW-1:0]  pat;
    logic [LW-1:0]  len;
    logic [LW-1:0]  bits_seen;
    logic [CW-1:0]  cnt;

    logic           sel_valid;
    logic [CHW-1:0] sel_ch;
    int             arb_idx;

    logic           cur_vld;
    logic           cur_bit;
    logic           cur_last;
    logic           cur_req;
    logic [PW-1:0]  new_hist;
    logic [PW-1:0]  len_mask;
    logic [LW:0]    seen_plus1;
    logic [LW-1:0]  seen_next;
    logic           hit;
    logic [CW-1:0]  cnt_next;
    logic [LW-1:0]  cfg_len_clamped;

    // Search starts one past the last served channel so every requester gets its turn.
    always_comb begin
        sel_valid = 1'b0;
        sel_ch    = '0;
        arb_idx   = 0;
        for (int i = 1; i <= NCH; i++) begin
            arb_idx = int'(rr_ptr) + i;
            if (arb_idx >= NCH) begin
                arb_idx = arb_idx - NCH;
            end
            if (!sel_valid && req[CHW'(arb_idx)]) begin
                sel_valid = 1'b1;
                sel_ch    = CHW'(arb_idx);
            end
        end
    end

    assign cfg_len_clamped = (cfg_len > LW'(PW)) ? LW'(PW) : cfg_len;

    assign cur_vld  = bit_vld[cur_ch];
    assign cur_bit  = bit_in[cur_ch];
    assign cur_last = bit_last[cur_ch];
    assign cur_req  = req[cur_ch];

    always_comb begin
        new_hist = {hist, cur_bit};
        len_mask = '0;
        for (int i = 0; i < PW; i++) begin
            len_mask[i] = (LW'(i) < len);
        end
        seen_plus1 = {1'b0, bits_seen} + (LW+1)'(1);
        seen_next  = (bits_seen == LW'(PW)) ? bits_seen : bits_seen + LW'(1);
        hit        = (len != '0) && (seen_plus1 >= {1'b0, len}) &&
                     (((new_hist ^ pat) & len_mask) == '0);
        cnt_next   = (cur_vld && hit && (cnt != {CW{1'b1}})) ? cnt + CW'(1) : cnt;
    end

    // Zero-latency hit strobe: the bit that completes the pattern is flagged in its own cycle.
    assign match_pulse = (state == RUN) && cur_vld && hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            grant     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            done_ch   <= '0;
            match_cnt <= '0;
            rr_ptr    <= CHW'(NCH - 1);
            cur_ch    <= '0;
            hist      <= '0;
            pat       <= '0;
            len       <= '0;
            bits_seen <= '0;
            cnt       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (sel_valid) begin
                        state     <= RUN;
                        grant     <= NCH'(1) << sel_ch;
                        busy      <= 1'b1;
                        rr_ptr    <= sel_ch;
                        cur_ch    <= sel_ch;
                        pat       <= cfg_pattern;
                        len       <= cfg_len_clamped;
                        hist      <= '0;
                        bits_seen <= '0;
                        cnt       <= '0;
                    end
                end
                RUN: begin
                    if (cur_vld) begin
`ifdef SEQ_MATCH_NONOVERLAP_EN
                        if (hit) begin
                            hist      <= '0;
                            bits_seen <= '0;
                        end else begin
                            hist      <= new_hist[PW-2:0];
                            bits_seen <= seen_next;
                        end
`else
                        hist      <= new_hist[PW-2:0];
                        bits_seen <= seen_next;
`endif
                        cnt <= cnt_next;
                    end
                    // The final bit is still scored, so the report includes a hit on it.
                    if (cur_vld && cur_last) begin
                        state     <= REPORT;
                        grant     <= '0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        done_ch   <= cur_ch;
                        match_cnt <= cnt_next;
                    end else if (!cur_req) begin
                        state <= IDLE;
                        grant <= '0;
                        busy  <= 1'b0;
                    end
                end
                REPORT: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
